ram_access_scheduler: RTL
=========================

Name: ram_access_scheduler

Overview:
Arbitrates the 2048x16 scratchpad RAM between the host load/store port and the tile-fetch requests from the compute sequencer. It serialises single-word host accesses and matrix+vector tile fetches into the RAM's one-hot control strobes. It validates tile geometry and address bounds, and reports completion and errors. It sits between the host/compute control logic and the random access memory.

Parameters:
DEPTH, 2048, RAM words; legal addresses are 0..DEPTH-1
DIM, 16, maximum matrix rows/cols and vector length
AW, 16, address/dimension width
DW, 16, data width
HOST_BURST, 4, maximum consecutive host grants while a tile request waits

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
host_req_valid  in  1  host request present
host_req_write  in  1  1=write, 0=read
host_addr  in  AW  host word address
host_wdata  in  DW  host write data
host_req_ready  out  1  host request accepted this cycle when valid
host_rdata_valid  out  1  RAM data_out holds the host read result this cycle
host_err  out  1  pulse: host address out of range, access dropped
tile_req_valid  in  1  tile fetch request present
tile_mat_addr  in  AW  matrix base address
tile_vec_addr  in  AW  vector base address
tile_m  in  AW  matrix rows; also row stride
tile_n  in  AW  matrix columns
tile_l  in  AW  vector length
tile_req_ready  out  1  tile request accepted
tile_done  out  1  pulse: RAM matrix_out/vector_out valid this cycle
tile_err  out  1  pulse: illegal tile, no RAM access
busy  out  1  state != IDLE or host strobe in flight
ram_write_block, ram_read_block, ram_read_matrix, ram_read_vector  out  1 each  RAM strobes
ram_address_block, ram_address_matrix, ram_address_vector  out  AW  RAM addresses
ram_matrix_M, ram_matrix_N, ram_vector_L  out  AW  RAM geometry
ram_data_in  out  DW  RAM write data

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; all outputs 0; streak counter 0; in-flight host read dropped, so there is no host_rdata_valid. Reset mid-fetch aborts with no tile_done.
- FSM states:
  - IDLE: accepts requests.
  - FETCH: drives ram_read_matrix=1 and ram_read_vector=1, with addresses/geometry from the latched request.
  - DONE: tile_done=1.
  - Transitions: IDLE->FETCH on a legal tile accept. FETCH->DONE unconditionally. DONE->IDLE unconditionally.
- Arbitration, evaluated in IDLE only:
  - The host has priority.
  - host_req_ready = IDLE && !(tile_req_valid && streak==HOST_BURST).
  - tile_req_ready = IDLE && tile_req_valid && (!host_req_valid || streak==HOST_BURST).
  - streak increments on each host accept while tile_req_valid=1. It saturates at HOST_BURST. It clears on tile accept or whenever tile_req_valid=0.
  - Both ready signals are 0 in FETCH and DONE.
- Host timing:
  - Accept at edge k. RAM strobe (write_block or read_block) is high for exactly cycle k+1, with the registered address/data.
  - For reads, host_rdata_valid=1 in cycle k+2.
  - Back-to-back accepts are allowed: one access per cycle, fully pipelined.
  - host_addr >= DEPTH: accepted, no strobe, host_err=1 in k+1.
- Tile timing:
  - Accept at edge k. FETCH is cycle k+1. tile_done is cycle k+2. IDLE resumes at k+3.
  - A host accept at k-1 strobes in cycle k, so RAM strobes never overlap.
- Tile legality, computed combinationally at accept:
  - Requires 1<=tile_m<=DIM, 1<=tile_n<=DIM, 1<=tile_l<=DIM.
  - Requires mat_addr + tile_m*(tile_m-1) + tile_n - 1 <= DEPTH-1, evaluated at 2*AW bits with no wrap.
  - Requires vec_addr + tile_l - 1 <= DEPTH-1.
  - An illegal tile is accepted, stays in IDLE, raises tile_err in k+1, resets streak and issues no strobe.
- Invariants:
  - At most one of write_block, read_block, and the read_matrix/read_vector pair is high in any cycle.
  - Strobes are single-cycle pulses.
  - Geometry/address outputs are 0 when their strobe is low.

Decomposition:
- Package ttpu_ram_pkg holds:
  - the state enum sched_state_t {IDLE, FETCH, DONE};
  - the constants RAM_DEPTH=2048, TILE_DIM=16, ADDR_W=16, DATA_W=16.
- Sub-module ram_tile_bounds_check holds the combinational geometry/range check. It outputs tile_legal.

Test Plan:
- Host write addr 0x0005 data 0xBEEF at edge k, then read 0x0005 at k+1 -> write_block in k+1, read_block in k+2, host_rdata_valid in k+3 with RAM data_out=0xBEEF.
- Tile m=4 n=3 l=4 mat=0x0100 vec=0x0200, host idle -> read_matrix and read_vector high in k+1 with M=4 N=3 L=4; tile_done in k+2; tile_req_ready=0 in k+1 and k+2.
- Host valid every cycle, tile valid from cycle 0, HOST_BURST=4 -> 4 host accepts, then a tile accept; host ready=0 through DONE; streak restarts.
- Tile m=17 -> tile_err pulse, no strobes. Tile mat=2040 m=4 n=4 (end=2055) -> tile_err. Host addr 2048 -> host_err, no strobe.
- Simultaneous host read and tile request with streak=0 -> host granted first, tile granted next cycle; strobes never overlap.
- rst_n=0 during FETCH -> next cycle all outputs 0, no tile_done; a new tile is accepted normally after release.

Source files
------------

// File: rtl/ttpu_ram_pkg.sv
// Shared types and sizing constants for the scratchpad RAM access scheduler.
package ttpu_ram_pkg;

  localparam int unsigned RAM_DEPTH = 2048;
  localparam int unsigned TILE_DIM  = 16;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } sched_state_t;

endpackage

// File: rtl/ram_tile_bounds_check.sv
// Combinational legality check for a tile fetch: dimension limits plus matrix
// and vector footprints that must stay inside the RAM.
module ram_tile_bounds_check #(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned DIM   = 16,
  parameter int unsigned AW    = 16
) (
  input  logic [AW-1:0] i_mat_addr,
  input  logic [AW-1:0] i_vec_addr,
  input  logic [AW-1:0] i_m,
  input  logic [AW-1:0] i_n,
  input  logic [AW-1:0] i_l,
  output logic          o_tile_legal
);

  // Double width so that no footprint sum can wrap.
  localparam int unsigned WW = 2 * AW;

  logic [WW-1:0] w_m, w_n, w_l, w_mat, w_vec;
  logic [WW-1:0] w_mat_end_p1, w_vec_end_p1;
  logic          w_dims_ok, w_mat_ok, w_vec_ok;

  function automatic logic dim_ok(input logic [WW-1:0] d);
    return (d >= WW'(1)) && (d <= WW'(DIM));
  endfunction

  assign w_m   = WW'(i_m);
  assign w_n   = WW'(i_n);
  assign w_l   = WW'(i_l);
  assign w_mat = WW'(i_mat_addr);
  assign w_vec = WW'(i_vec_addr);

  // Row stride is m, so the last element sits at mat + m*(m-1) + n - 1.
  // Comparing the one-past-end against DEPTH avoids an extra subtract.
  assign w_mat_end_p1 = w_mat + (w_m * (w_m - WW'(1))) + w_n;
  assign w_vec_end_p1 = w_vec + w_l;

  assign w_dims_ok    = dim_ok(w_m) && dim_ok(w_n) && dim_ok(w_l);
  assign w_mat_ok     = w_mat_end_p1 <= WW'(DEPTH);
  assign w_vec_ok     = w_vec_end_p1 <= WW'(DEPTH);
  assign o_tile_legal = w_dims_ok && w_mat_ok && w_vec_ok;

endmodule

// File: rtl/ram_access_scheduler.sv
// Arbitrates the scratchpad RAM between single-word host accesses and
// matrix+vector tile fetches, driving the RAM's one-hot strobes.
module ram_access_scheduler
  import ttpu_ram_pkg::*;
#(
  parameter int unsigned DEPTH      = RAM_DEPTH,
  parameter int unsigned DIM        = TILE_DIM,
  parameter int unsigned AW         = ADDR_W,
  parameter int unsigned DW         = DATA_W,
  parameter int unsigned HOST_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          host_req_valid,
  input  logic          host_req_write,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_req_ready,
  output logic          host_rdata_valid,
  output logic          host_err,
  input  logic          tile_req_valid,
  input  logic [AW-1:0] tile_mat_addr,
  input  logic [AW-1:0] tile_vec_addr,
  input  logic [AW-1:0] tile_m,
  input  logic [AW-1:0] tile_n,
  input  logic [AW-1:0] tile_l,
  output logic          tile_req_ready,
  output logic          tile_done,
  output logic          tile_err,
  output logic          busy,
  output logic          ram_write_block,
  output logic          ram_read_block,
  output logic          ram_read_matrix,
  output logic          ram_read_vector,
  output logic [AW-1:0] ram_address_block,
  output logic [AW-1:0] ram_address_matrix,
  output logic [AW-1:0] ram_address_vector,
  output logic [AW-1:0] ram_matrix_M,
  output logic [AW-1:0] ram_matrix_N,
  output logic [AW-1:0] ram_vector_L,
  output logic [DW-1:0] ram_data_in
);

  localparam int unsigned SW = $clog2(HOST_BURST + 1);

  sched_state_t  r_state, w_state_next;
  logic [SW-1:0] r_streak;
  logic          r_host_wr, r_host_rd, r_host_err, r_rdata_valid;
  logic [AW-1:0] r_host_addr;
  logic [DW-1:0] r_host_wdata;
  logic          r_tile_err;
  logic [AW-1:0] r_mat_addr, r_vec_addr, r_m, r_n, r_l;

  logic w_idle, w_burst_full, w_host_acc, w_tile_acc, w_host_in_range, w_tile_legal;

  ram_tile_bounds_check #(
    .DEPTH (DEPTH),
    .DIM   (DIM),
    .AW    (AW)
  ) u_bounds (
    .i_mat_addr   (tile_mat_addr),
    .i_vec_addr   (tile_vec_addr),
    .i_m          (tile_m),
    .i_n          (tile_n),
    .i_l          (tile_l),
    .o_tile_legal (w_tile_legal)
  );

  assign w_idle       = (r_state == IDLE);
  assign w_burst_full = (r_streak == SW'(HOST_BURST));

  // Readies are gated by reset so every output reads 0 while reset is held.
  assign host_req_ready  = rst_n && w_idle && !(tile_req_valid && w_burst_full);
  assign tile_req_ready  = rst_n && w_idle && tile_req_valid && (!host_req_valid || w_burst_full);
  assign w_host_acc      = host_req_valid && host_req_ready;
  assign w_tile_acc      = tile_req_valid && tile_req_ready;
  assign w_host_in_range = (32'(host_addr) < DEPTH);

  // Host pipeline: accepted access becomes a one-cycle strobe, read data follows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_host_wr     <= 1'b0;
      r_host_rd     <= 1'b0;
      r_host_err    <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_host_addr   <= '0;
      r_host_wdata  <= '0;
    end else begin
      r_host_wr     <= w_host_acc && host_req_write && w_host_in_range;
      r_host_rd     <= w_host_acc && !host_req_write && w_host_in_range;
      r_host_err    <= w_host_acc && !w_host_in_range;
      r_rdata_valid <= r_host_rd;
      if (w_host_acc) begin
        r_host_addr  <= host_addr;
        r_host_wdata <= host_wdata;
      end
    end
  end

  // Host-grant streak: bounds how long a waiting tile can be starved.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (!tile_req_valid || w_tile_acc) begin
      r_streak <= '0;
    end else if (w_host_acc && !w_burst_full) begin
      r_streak <= r_streak + SW'(1);
    end
  end

  // Tile request latch and illegal-tile error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tile_err <= 1'b0;
      r_mat_addr <= '0;
      r_vec_addr <= '0;
      r_m        <= '0;
      r_n        <= '0;
      r_l        <= '0;
    end else begin
      r_tile_err <= w_tile_acc && !w_tile_legal;
      if (w_tile_acc) begin
        r_mat_addr <= tile_mat_addr;
        r_vec_addr <= tile_vec_addr;
        r_m        <= tile_m;
        r_n        <= tile_n;
        r_l        <= tile_l;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state and tile-side RAM outputs.
  always_comb begin
    w_state_next       = r_state;
    ram_read_matrix    = 1'b0;
    ram_read_vector    = 1'b0;
    ram_address_matrix = '0;
    ram_address_vector = '0;
    ram_matrix_M       = '0;
    ram_matrix_N       = '0;
    ram_vector_L       = '0;
    tile_done          = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_tile_acc && w_tile_legal) w_state_next = FETCH;
      end
      FETCH: begin
        w_state_next       = DONE;
        ram_read_matrix    = 1'b1;
        ram_read_vector    = 1'b1;
        ram_address_matrix = r_mat_addr;
        ram_address_vector = r_vec_addr;
        ram_matrix_M       = r_m;
        ram_matrix_N       = r_n;
        ram_vector_L       = r_l;
      end
      DONE: begin
        w_state_next = IDLE;
        tile_done    = 1'b1;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign ram_write_block   = r_host_wr;
  assign ram_read_block    = r_host_rd;
  assign ram_address_block = (r_host_wr || r_host_rd) ? r_host_addr : '0;
  assign ram_data_in       = r_host_wr ? r_host_wdata : '0;
  assign host_rdata_valid  = r_rdata_valid;
  assign host_err          = r_host_err;
  assign tile_err          = r_tile_err;
  assign busy              = !w_idle || r_host_wr || r_host_rd;

endmodule
